scalar_exec_unit: RTL and testbench
===================================

Name: scalar_exec_unit

Overview:
- Sequential execute stage that issues scalar ALU operations and returns registered results and flags.
- Sits between decode/register-read and writeback in the scalar pipeline.
- Uses the scalar ALU opcode encoding. Single-cycle ops complete in 1 cycle; DIV runs as an iterative multi-cycle restoring divider instead of a combinational divide.
- Valid/ready handshake on both input and output. At most one operation in flight.

Parameters:
- DATA_W, 16, operand/result width.
- TAG_W, 4, destination-register tag width, carried unchanged from input to output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_sel  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 ASR, 101 LSR, 110 LSL, 111 AND.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_c  out  DATA_W  result.
- out_flagZ  out  1  out_c == 0.
- out_flagN  out  1  out_c[DATA_W-1].
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  divider active.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_c=0, out_flagZ=0, out_flagN=0, out_tag=0, busy=0, state=IDLE.
- Reset mid-division aborts the operation with no output.
- FSM states: IDLE, DIV, RESP.
- in_ready = (state==IDLE) || (state==RESP && out_ready). This is combinational from out_ready, which allows back-to-back single-cycle ops at 1 per cycle.
- Accept of a non-DIV op: result, flags and tag are registered; next state is RESP; out_valid=1 on the following cycle (latency 1).
- Accept of DIV: latch operands and tag; state DIV; busy=1. After exactly DATA_W iterations, load result and go to RESP. Latency is DATA_W+1 cycles from accept to out_valid (17 by default).
- RESP: out_c, out_flagZ, out_flagN and out_tag are held stable while out_valid && !out_ready.
  - On out_ready without a new accept: go to IDLE, out_valid=0.
  - On out_ready with a simultaneous accept: follow the accept rules above.
- Arithmetic rules (all results truncated to DATA_W):
  - ADD/SUB: modulo 2^DATA_W.
  - MUL: low DATA_W bits of the product.
  - DIV: unsigned quotient. B==0 gives all-ones (0xFFFF) and busy stays 0; the result is ready on the next cycle (latency 1).
  - Shift amount is in_b; any value >= DATA_W saturates. ASR fills with the sign bit (result 0 or all-ones); LSR/LSL give 0.
  - AND: bitwise.
- Flags are always derived from the final out_c.
- in_valid while in_ready=0: the op is held by the producer; no implicit drop.

Optional Feature:
- Macro: SCALAR_DIV_SIGNED_EN.
- With the macro: DIV is signed two's complement, quotient truncated toward zero. Magnitudes are divided and the sign is fixed up in the final cycle, so latency is unchanged. Most-negative / -1 gives 0x8000. Divide by zero still gives 0xFFFF.
- Without the macro: unsigned DIV only.

Decomposition:
- Package scalar_alu_pkg holds:
  - DATA_W default constant.
  - enum alu_op_e with the 3-bit encodings above.
  - state enum exec_state_e.
- Sub-module scalar_divider: start/done handshake, iterative restoring divider, DATA_W cycles, signed fixup under the macro.
- ALU datapath for single-cycle ops stays inline.

Test Plan:
- Reset then ADD 8+5, out_ready=1 -> out_valid one cycle after accept, out_c=13, Z=0, N=0. Then SUB 5-5 -> out_c=0, Z=1.
- Back-to-back MUL 5*6, LSL 4<<2, AND 15&10 on consecutive cycles with out_ready=1 -> in_ready stays high; outputs 30, 16, 10 on consecutive cycles with matching tags.
- DIV 20/4 -> busy=1, in_ready=0 for 16 cycles; out_c=5 exactly 17 cycles after accept. DIV 7/0 -> 0xFFFF after 1 cycle.
- ASR 0x8000 by 2 -> 0xE000, N=1. LSR 0x8000 by 2 -> 0x2000. LSR by 20 -> 0, Z=1. ASR 0x8000 by 20 -> 0xFFFF.
- out_ready=0 for 5 cycles after ADD 1+1 -> out_valid, out_c=2 and tag held stable; in_ready=0 until release.
- Assert rst 8 cycles into DIV 100/3 -> next cycle out_valid=0, busy=0, in_ready=1; a following ADD 2+2 returns 4. With SCALAR_DIV_SIGNED_EN: DIV -20/3 -> 0xFFFA (-6).

Source files
------------

// File: rtl/scalar_exec_unit_pkg.sv
// Shared types for the scalar execute stage: ALU opcode encoding, FSM states, default widths.
package scalar_alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TAG_W_DEF  = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_ASR = 3'b100,
        OP_LSR = 3'b101,
        OP_LSL = 3'b110,
        OP_AND = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RESP = 2'd2
    } exec_state_e;

endpackage

// File: rtl/scalar_exec_unit_if.sv
// Issue/result handshake bundle between register-read, the execute stage and writeback.
interface scalar_exec_unit_if
    import scalar_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [2:0]        in_sel;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_c;
    logic              out_flagZ;
    logic              out_flagN;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_flagZ, out_flagN, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_flagZ, out_flagN, out_tag, busy
    );
endinterface

// File: rtl/scalar_exec_unit_divider.sv
// Iterative restoring divider, one quotient bit per cycle over DATA_W cycles.
// SCALAR_DIV_SIGNED_EN: divide magnitudes and negate the quotient on the last cycle.
module scalar_divider
    import scalar_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] q_o
);
    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic              running_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;

    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

`ifdef SCALAR_DIV_SIGNED_EN
    logic neg_q;

    assign a_mag = a_i[DATA_W-1] ? -a_i : a_i;
    assign b_mag = b_i[DATA_W-1] ? -b_i : b_i;
    assign q_o   = neg_q ? -quo_n : quo_n;
`else
    assign a_mag = a_i;
    assign b_mag = b_i;
    assign q_o   = quo_n;
`endif

    // Remainder stays below the divisor, so the W-bit subtraction never loses a carry.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign rem_n   = ge ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
    assign quo_n   = {quo_q[DATA_W-2:0], ge};
    assign done_o  = running_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
`ifdef SCALAR_DIV_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
`ifdef SCALAR_DIV_SIGNED_EN
            neg_q     <= a_i[DATA_W-1] ^ b_i[DATA_W-1];
`endif
        end else if (running_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/scalar_exec_unit.sv
// Scalar execute stage: single-cycle ALU ops plus a multi-cycle divider, one op in flight.
// Define SCALAR_DIV_SIGNED_EN for signed two's-complement DIV.
module scalar_exec_unit
    import scalar_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    scalar_exec_unit_if.slave bus
);
    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] out_c_q, out_c_d;
    logic              out_z_q, out_z_d;
    logic              out_n_q, out_n_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    alu_op_e           op;
    logic              in_ready;
    logic              accept;
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] res_sel;
    logic              load_res;

    assign op        = alu_op_e'(bus.in_sel);
    assign in_ready  = (state_q == IDLE) || ((state_q == RESP) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign div_start = accept && (op == OP_DIV) && (bus.in_b != '0);

    scalar_divider #(.DATA_W(DATA_W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .a_i     (bus.in_a),
        .b_i     (bus.in_b),
        .done_o  (div_done),
        .q_o     (div_q)
    );

    // Shifts by >= DATA_W saturate through the language's own shift semantics.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = bus.in_a + bus.in_b;
            OP_SUB:  alu_res = bus.in_a - bus.in_b;
            OP_MUL:  alu_res = bus.in_a * bus.in_b;
            OP_DIV:  alu_res = '1;
            OP_ASR:  alu_res = $signed(bus.in_a) >>> bus.in_b;
            OP_LSR:  alu_res = bus.in_a >> bus.in_b;
            OP_LSL:  alu_res = bus.in_a << bus.in_b;
            OP_AND:  alu_res = bus.in_a & bus.in_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        out_tag_d = out_tag_q;
        load_res  = 1'b0;
        res_sel   = alu_res;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    out_tag_d = bus.in_tag;
                    if (div_start) begin
                        state_d = DIV;
                    end else begin
                        load_res = 1'b1;
                        state_d  = RESP;
                    end
                end else if ((state_q == RESP) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done) begin
                    load_res = 1'b1;
                    res_sel  = div_q;
                    state_d  = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        out_c_d = load_res ? res_sel : out_c_q;
        out_z_d = load_res ? (res_sel == '0) : out_z_q;
        out_n_d = load_res ? res_sel[DATA_W-1] : out_n_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_c_q   <= '0;
            out_z_q   <= 1'b0;
            out_n_q   <= 1'b0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            out_c_q   <= out_c_d;
            out_z_q   <= out_z_d;
            out_n_q   <= out_n_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == RESP);
    assign bus.out_c     = out_c_q;
    assign bus.out_flagZ = out_z_q;
    assign bus.out_flagN = out_n_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.busy      = (state_q == DIV);

endmodule

// File: tb/tb_scalar_exec_unit.sv
// Self-checking bench for scalar_exec_unit: directed scenarios plus randomized ops against an arithmetic model.
module tb_scalar_exec_unit;
    import scalar_alu_pkg::*;

    localparam int W  = 16;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    scalar_exec_unit_if #(.DATA_W(W), .TAG_W(TW)) bus ();

    scalar_exec_unit #(.DATA_W(W), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Reference model: results from plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        longint d;
        r = 0;
        case (alu_op_e'(op))
            OP_ADD: r = (ua + ub) % m;
            OP_SUB: r = (ua - ub + m) % m;
            OP_MUL: r = (ua * ub) % m;
            OP_DIV: begin
                if (ub == 0) r = m - 1;
                else begin
`ifdef SCALAR_DIV_SIGNED_EN
                    r = sa / sb;
                    r = ((r % m) + m) % m;
`else
                    r = ua / ub;
`endif
                end
            end
            OP_ASR: begin
                if (ub >= W) r = (sa < 0) ? m - 1 : 0;
                else begin
                    d = longint'(1) << ub;
                    r = sa / d;
                    if (sa < 0 && (sa % d) != 0) r = r - 1;
                    r = (r + m) % m;
                end
            end
            OP_LSR: r = (ub >= W) ? 0 : ua / (longint'(1) << ub);
            OP_LSL: r = (ub >= W) ? 0 : (ua * (longint'(1) << ub)) % m;
            default: r = longint'(a & b);
        endcase
        return W'(r);
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] b);
        return (alu_op_e'(op) == OP_DIV && b != '0) ? W + 1 : 1;
    endfunction

    // Offer one op and return at #1 after the edge that accepted it.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input string name);
        bus.in_valid = 1'b1;
        bus.in_sel   = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s accept: in_ready stayed low for 100 cycles", name);
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the accept edge to out_valid (1 = visible right after the accept edge).
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc <= 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_c !== 16'h0000 || bus.out_flagZ !== 1'b0 ||
            bus.out_flagN !== 1'b0 || bus.out_tag !== 4'h0 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b c=%h z=%b n=%b tag=%h busy=%b rdy=%b, expected 0 0000 0 0 0 0 1",
                     bus.out_valid, bus.out_c, bus.out_flagZ, bus.out_flagN, bus.out_tag,
                     bus.busy, bus.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        int cyc;
        send(OP_ADD, 16'd8, 16'd5, 4'd3, "add");
        wait_valid(cyc);
        checks++;
        if (cyc !== 1 || bus.out_c !== 16'd13 || bus.out_flagZ !== 1'b0 ||
            bus.out_flagN !== 1'b0 || bus.out_tag !== 4'd3) begin
            errors++;
            $display("FAIL add: lat=%0d c=%h z=%b n=%b tag=%h, expected 1 000d 0 0 3",
                     cyc, bus.out_c, bus.out_flagZ, bus.out_flagN, bus.out_tag);
        end
        send(OP_SUB, 16'd5, 16'd5, 4'd4, "sub");
        wait_valid(cyc);
        checks++;
        if (cyc !== 1 || bus.out_c !== 16'd0 || bus.out_flagZ !== 1'b1 ||
            bus.out_flagN !== 1'b0 || bus.out_tag !== 4'd4) begin
            errors++;
            $display("FAIL sub: lat=%0d c=%h z=%b n=%b tag=%h, expected 1 0000 1 0 4",
                     cyc, bus.out_c, bus.out_flagZ, bus.out_flagN, bus.out_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]    ops[3];
        logic [W-1:0]  av[3];
        logic [W-1:0]  bv[3];
        logic [W-1:0]  ev[3];
        ops = '{OP_MUL, OP_LSL, OP_AND};
        av  = '{16'd5, 16'd4, 16'd15};
        bv  = '{16'd6, 16'd2, 16'd10};
        ev  = '{16'd30, 16'd16, 16'd10};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = ops[i];
            bus.in_a     = av[i];
            bus.in_b     = bv[i];
            bus.in_tag   = TW'(i + 8);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b ready[%0d]: in_ready=%b, expected 1", i, bus.in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_c !== ev[i] || bus.out_tag !== TW'(i + 8)) begin
                errors++;
                $display("FAIL b2b result[%0d]: valid=%b c=%h tag=%h, expected 1 %h %h",
                         i, bus.out_valid, bus.out_c, bus.out_tag, ev[i], TW'(i + 8));
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_div();
        int cyc;
        send(OP_DIV, 16'd20, 16'd4, 4'd5, "div");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL div busy[%0d]: busy=%b rdy=%b valid=%b, expected 1 0 0",
                         i, bus.busy, bus.in_ready, bus.out_valid);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_c !== 16'd5 || bus.out_tag !== 4'd5 ||
            bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL div result: valid=%b c=%h tag=%h busy=%b, expected 1 0005 5 0",
                     bus.out_valid, bus.out_c, bus.out_tag, bus.busy);
        end
        send(OP_DIV, 16'd7, 16'd0, 4'd6, "div0");
        wait_valid(cyc);
        checks++;
        if (cyc !== 1 || bus.out_c !== 16'hFFFF || bus.busy !== 1'b0 ||
            bus.out_flagN !== 1'b1 || bus.out_tag !== 4'd6) begin
            errors++;
            $display("FAIL div0: lat=%0d c=%h busy=%b n=%b tag=%h, expected 1 ffff 0 1 6",
                     cyc, bus.out_c, bus.busy, bus.out_flagN, bus.out_tag);
        end
    endtask

    task automatic test_shift();
        logic [2:0]   ops[4];
        logic [W-1:0] av[4];
        logic [W-1:0] bv[4];
        logic [W-1:0] ev[4];
        int           cyc;
        ops = '{OP_ASR, OP_LSR, OP_LSR, OP_ASR};
        av  = '{16'h8000, 16'h8000, 16'h1234, 16'h8000};
        bv  = '{16'd2, 16'd2, 16'd20, 16'd20};
        ev  = '{16'hE000, 16'h2000, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], av[i], bv[i], TW'(i), "shift");
            wait_valid(cyc);
            checks++;
            if (cyc !== 1 || bus.out_c !== ev[i] || bus.out_flagZ !== (ev[i] == '0) ||
                bus.out_flagN !== ev[i][W-1]) begin
                errors++;
                $display("FAIL shift[%0d]: lat=%0d c=%h z=%b n=%b, expected 1 %h %b %b",
                         i, cyc, bus.out_c, bus.out_flagZ, bus.out_flagN, ev[i],
                         (ev[i] == '0), ev[i][W-1]);
            end
        end
    endtask

    task automatic test_hold();
        int cyc;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(OP_ADD, 16'd1, 16'd1, 4'd9, "hold");
        wait_valid(cyc);
        bus.in_valid = 1'b1;
        bus.in_sel   = OP_ADD;
        bus.in_a     = 16'd3;
        bus.in_b     = 16'd3;
        bus.in_tag   = 4'd10;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_c !== 16'd2 || bus.out_tag !== 4'd9 ||
                bus.out_flagZ !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b c=%h tag=%h z=%b rdy=%b, expected 1 0002 9 0 0",
                         i, bus.out_valid, bus.out_c, bus.out_tag, bus.out_flagZ, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold release: in_ready=%b, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_c !== 16'd6 || bus.out_tag !== 4'd10) begin
            errors++;
            $display("FAIL hold next: valid=%b c=%h tag=%h, expected 1 0006 a",
                     bus.out_valid, bus.out_c, bus.out_tag);
        end
    endtask

    task automatic test_reset_div();
        int cyc;
        int seen;
        send(OP_DIV, 16'd100, 16'd3, 4'd7, "rstdiv");
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset mid-div: valid=%b busy=%b rdy=%b, expected 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        send(OP_ADD, 16'd2, 16'd2, 4'd6, "add after reset");
        wait_valid(cyc);
        checks++;
        if (cyc !== 1 || bus.out_c !== 16'd4 || bus.out_tag !== 4'd6) begin
            errors++;
            $display("FAIL add after reset: lat=%0d c=%h tag=%h, expected 1 0004 6",
                     cyc, bus.out_c, bus.out_tag);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL aborted div: %0d cycles with valid/busy after abort, expected 0", seen);
        end
    endtask

    task automatic test_signed_div();
`ifdef SCALAR_DIV_SIGNED_EN
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        logic [W-1:0] ev[3];
        int           cyc;
        av = '{16'hFFEC, 16'd20, 16'h8000};
        bv = '{16'd3, 16'hFFFD, 16'hFFFF};
        ev = '{16'hFFFA, 16'hFFFA, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            send(OP_DIV, av[i], bv[i], TW'(i + 1), "sdiv");
            wait_valid(cyc);
            checks++;
            if (cyc !== W + 1 || bus.out_c !== ev[i] || bus.out_flagN !== 1'b1) begin
                errors++;
                $display("FAIL signed div[%0d]: lat=%0d c=%h n=%b, expected %0d %h 1",
                         i, cyc, bus.out_c, bus.out_flagN, W + 1, ev[i]);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp_c;
        int            exp_lat;
        int            cyc;
        int            hold;
        int            bad;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = W'($urandom);
            tag = TW'($urandom);
            if (op >= 3'd4 && op <= 3'd6) b = W'($urandom_range(0, 24));
            else if (op == 3'd3 && $urandom_range(0, 7) == 0) b = '0;
            else if (op == 3'd3 && $urandom_range(0, 1) == 0) b = W'($urandom_range(1, 300));
            else b = W'($urandom);
            exp_c   = ref_result(op, a, b);
            exp_lat = ref_latency(op, b);
            send(op, a, b, tag, "random");
            wait_valid(cyc);
            checks++;
            if (cyc !== exp_lat || bus.out_c !== exp_c || bus.out_tag !== tag ||
                bus.out_flagZ !== (exp_c == '0) || bus.out_flagN !== exp_c[W-1]) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d c=%h z=%b n=%b tag=%h, expected %0d %h %b %b %h",
                         n, op, a, b, cyc, bus.out_c, bus.out_flagZ, bus.out_flagN, bus.out_tag,
                         exp_lat, exp_c, (exp_c == '0), exp_c[W-1], tag);
            end
            hold = $urandom_range(0, 2);
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                bad = 0;
                repeat (hold) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid !== 1'b1 || bus.out_c !== exp_c || bus.out_tag !== tag) bad++;
                end
                checks++;
                if (bad !== 0) begin
                    errors++;
                    $display("FAIL random hold[%0d]: %0d unstable cycles, expected 0", n, bad);
                end
                bus.out_ready = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_div();
        test_shift();
        test_hold();
        test_reset_div();
        test_signed_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
